inst_mem_loader: RTL



---
 rtl/loader_pkg.sv | 17 +
 rtl/byte_to_word_packer.sv | 44 ++++
 rtl/inst_mem_loader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, byte lanes
// and the instruction address width used by the memory and the PC.
package loader_pkg;

  localparam int INST_AW = 6;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RECV  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_CKSUM = 3'd4;

  // Big-endian stream: lane 0 lands in [31:24], lane 3 in [7:0].
  localparam logic [1:0] LANE_FIRST = 2'd0;
  localparam logic [1:0] LANE_LAST  = 2'd3;

endpackage

// File: rtl/byte_to_word_packer.sv
// Assembles four big-endian bytes into a 32-bit word; word_valid_o flags the
// cycle in which the fourth byte is taken and word_o carries the full word.
module byte_to_word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        take_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] shift_q, shift_d;

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    lane_d  = lane_q;
    shift_d = shift_q;
    if (clear_i) begin
      lane_d = LANE_FIRST;
    end else if (take_i) begin
      lane_d  = lane_q + 2'd1;
      shift_d = {shift_q[15:0], byte_i};
    end
  end

  assign word_valid_o = take_i && !clear_i && (lane_q == LANE_LAST);
  assign word_o       = {shift_q, byte_i};

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (!rst_n) begin
      lane_q  <= LANE_FIRST;
      shift_q <= '0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Byte-stream loader for the instruction RAM; holds the CPU in reset while loading.
// Optional trailing XOR checksum byte enabled by `define INST_LOADER_CHECKSUM_EN.
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int AW         = INST_AW,
  parameter int WORD_COUNT = 64,
  parameter int START_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          cpu_hold,
  output logic          err
);

  localparam int            CW       = $clog2(WORD_COUNT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WORD_COUNT);
  localparam logic [AW-1:0] START_A  = AW'(START_ADDR);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          start_ok;
  logic          pack_take;
  logic          word_valid;
  logic [31:0]   word;

`ifdef INST_LOADER_CHECKSUM_EN
  logic          err_q, err_d;
  logic [7:0]    cks_q, cks_d;
  assign byte_ready = (state_q == ST_RECV) || (state_q == ST_CKSUM);
  assign err        = err_q;
`else
  assign byte_ready = (state_q == ST_RECV);
  assign err        = 1'b0;
`endif

  assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign pack_take = byte_valid && (state_q == ST_RECV);
  assign cnt_inc   = cnt_q + CW'(1);

  byte_to_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (start_ok),
    .take_i       (pack_take),
    .byte_i       (byte_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef INST_LOADER_CHECKSUM_EN
    err_d   = err_q;
    cks_d   = cks_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RECV;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          addr_d  = START_A;
          cnt_d   = '0;
`ifdef INST_LOADER_CHECKSUM_EN
          err_d   = 1'b0;
          cks_d   = '0;
`endif
        end
      end
      ST_RECV: begin
`ifdef INST_LOADER_CHECKSUM_EN
        if (byte_valid) cks_d = cks_q ^ byte_data;
`endif
        if (word_valid) begin
          wdata_d = word;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_inc;
        if (cnt_inc == LAST_CNT) begin
`ifdef INST_LOADER_CHECKSUM_EN
          state_d = ST_CKSUM;
`else
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end else begin
          addr_d  = addr_q + AW'(1);
          state_d = ST_RECV;
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      ST_CKSUM: begin
        if (byte_valid) begin
          if (byte_data != cks_q) err_d = 1'b1;
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= START_A;
      wdata_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      err_q   <= 1'b0;
      cks_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef INST_LOADER_CHECKSUM_EN
      err_q   <= err_d;
      cks_q   <= cks_d;
`endif
    end
  end

  assign mem_we    = (state_q == ST_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cpu_hold  = busy_q;

endmodule
